alu_operand_stage: RTL

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

---
 rtl/alu_operand_stage.sv | 104 ++++++++++
 1 files changed

// File: rtl/alu_operand_stage.sv
// Operand fetch stage: 8x8 register file, valid/ready skid-free output register, ALU write-back port.
// Define ALU_OPERAND_STAGE_BYPASS_EN to forward same-cycle write-back data into captured operands.
module alu_operand_stage (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_ctrl,
    input  logic [2:0] in_ra,
    input  logic [2:0] in_rb,
    input  logic [2:0] in_rd,
    input  logic       in_imm_en,
    input  logic [7:0] in_imm,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] ctrl,
    output logic [7:0] x,
    output logic [7:0] y,
    output logic [2:0] out_rd,
    input  logic       wb_en,
    input  logic [2:0] wb_addr,
    input  logic [7:0] wb_data,
    input  logic       wb_carry,
    output logic       carry_flag
);

    logic [7:0] rf_q [8];
    logic [7:0] rf_d [8];
    logic       out_valid_q, out_valid_d;
    logic [7:0] x_q, x_d, y_q, y_d;
    logic [3:0] ctrl_q, ctrl_d;
    logic [2:0] out_rd_q, out_rd_d;
    logic       carry_q, carry_d;

    logic       accept;
    logic       wb_live;
    logic [7:0] rd_a, rd_b;

    assign wb_live = wb_en && (wb_addr != 3'd0);

    always_comb begin
        rd_a = (in_ra == 3'd0) ? 8'h00 : rf_q[in_ra];
        rd_b = (in_rb == 3'd0) ? 8'h00 : rf_q[in_rb];
`ifdef ALU_OPERAND_STAGE_BYPASS_EN
        // r0 is excluded through wb_live, so forwarding never makes r0 nonzero
        if (wb_live && (wb_addr == in_ra)) rd_a = wb_data;
        if (wb_live && (wb_addr == in_rb)) rd_b = wb_data;
`endif
    end

    always_comb begin
        in_ready    = !out_valid_q || out_ready;
        accept      = in_valid && in_ready;
        out_valid_d = out_valid_q;
        x_d         = x_q;
        y_d         = y_q;
        ctrl_d      = ctrl_q;
        out_rd_d    = out_rd_q;
        if (accept) begin
            out_valid_d = 1'b1;
            x_d         = rd_a;
            y_d         = in_imm_en ? in_imm : rd_b;
            ctrl_d      = in_ctrl;
            out_rd_d    = in_rd;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        rf_d = rf_q;
        if (wb_live) rf_d[wb_addr] = wb_data;
        // carry tracks every write-back, including the discarded r0 ones
        carry_d = wb_en ? wb_carry : carry_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) rf_q[i] <= 8'h00;
            out_valid_q <= 1'b0;
            x_q         <= 8'h00;
            y_q         <= 8'h00;
            ctrl_q      <= 4'h0;
            out_rd_q    <= 3'd0;
            carry_q     <= 1'b0;
        end else begin
            rf_q        <= rf_d;
            out_valid_q <= out_valid_d;
            x_q         <= x_d;
            y_q         <= y_d;
            ctrl_q      <= ctrl_d;
            out_rd_q    <= out_rd_d;
            carry_q     <= carry_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign x          = x_q;
    assign y          = y_q;
    assign ctrl       = ctrl_q;
    assign out_rd     = out_rd_q;
    assign carry_flag = carry_q;

endmodule
